alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (8..64).
REQ-002 SHALL have parameter STEP, default 1, shift bits per cycle (power of 2, 1..WIDTH).
REQ-003 SHALL have derived localparam SHW = clog2(WIDTH), shift-amount width.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  operation request.
REQ-007 SHALL have port in_ready  out  1  block can accept an operation.
REQ-008 SHALL have port os  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
REQ-009 SHALL have ports sr1, sr2  in  WIDTH  operands.
REQ-010 SHALL have port shift  in  SHW  shift amount applied to sr1.
REQ-011 SHALL have port out_valid  out  1  result available.
REQ-012 SHALL have port out_ready  in  1  consumer accepts result.
REQ-013 SHALL have port rd  out  WIDTH  result.
REQ-014 SHALL have ports zeroflag, negflag, carryflag, ovflag  out  1 each  result flags.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready, latching os, sr1, sr2, shift.
REQ-018 SHALL, for opcodes 000-100, register the result and enter DONE on the accept edge: out_valid high one cycle after accept.
REQ-019 SHALL, for 101-111 with shift==0, enter DONE directly with rd=sr1, carryflag=0.
REQ-020 SHALL, for 101-111 with shift>0, enter SHIFT and shift by min(STEP, remaining) per cycle; enter DONE when remaining reaches 0: out_valid high ceil(shift/STEP)+1 cycles after accept.
REQ-021 SHALL fill SLL/SRL with zeros and SRA with copies of the sign bit (bit WIDTH-1).
REQ-022 SHALL hold rd, flags and out_valid stable in DONE until out_ready; DONE && out_ready -> IDLE next cycle.
REQ-023 SHALL not accept a new operation in the DONE/out_ready cycle; maximum throughput is one op per 2 cycles.
REQ-024 SHALL ignore in_valid, os and operand changes outside IDLE.
REQ-025 SHALL compute ADD/SUB modulo 2^WIDTH; carryflag = carry-out for ADD, borrow (sr1<sr2 unsigned) for SUB.
REQ-026 SHALL set ovflag on signed overflow for ADD/SUB; 0 for all other opcodes.
REQ-027 SHALL set carryflag for shifts to the last bit shifted out; 0 for logic ops.
REQ-028 SHALL set zeroflag = (rd==0) and negflag = rd[WIDTH-1] for every opcode.
REQ-029 SHALL keep out_valid low and flags unchanged-from-reset until the first result.

Reset
REQ-030 SHALL, on reset_n low, asynchronously enter IDLE and force rd=0, out_valid=0, busy=0 and all flags to 0; in_ready is high in IDLE.
REQ-031 SHALL abort any operation in SHIFT or DONE on reset with no result emitted.
REQ-032 SHALL release reset synchronously to clk (external synchroniser); first accept possible on the first edge after release.

Structure
REQ-033 SHALL place opcode constants and the FSM state encoding in shared package alu_pkg.
REQ-034 SHALL implement the per-cycle shift in one combinational sub-module alu_shift_step (data, amount<=STEP, mode -> data, shifted-out bit).
REQ-035 SHALL fit in 120-400 lines of RTL, including the sub-module.

Verification (WIDTH=32, STEP=1 unless stated)
REQ-036 SHALL cover ADD sr1=0x9, sr2=0x1 -> rd=0xA, out_valid 1 cycle after accept, all flags 0.
REQ-037 SHALL cover SUB 0x1-0x1 -> rd=0, zeroflag=1; ADD 0x7FFFFFFF+0x1 -> rd=0x80000000, ovflag=1, negflag=1.
REQ-038 SHALL cover SLL sr1=0x9, shift=2 -> rd=0x24, out_valid 3 cycles after accept; with STEP=4 and shift=31, SRA 0x80000000 -> 0xFFFFFFFF after 9 cycles.
REQ-039 SHALL cover backpressure: out_ready low 5 cycles in DONE -> rd/flags stable, in_ready low; out_ready high -> IDLE next cycle.
REQ-040 SHALL cover reset_n pulsed low mid-SHIFT -> immediate IDLE, out_valid=0, rd=0; next op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the multi-cycle shifter: shifts data by amt_i (0..STEP)
// and reports the last bit shifted out (0 when amt_i is 0).
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]           data_i,
    input  logic [$clog2(STEP+1)-1:0]  amt_i,
    input  op_e                        mode_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       out_bit_o
);

    // One guard bit beyond the word catches the last bit shifted out.
    logic [WIDTH:0] sll_w;
    logic [WIDTH:0] srl_w;
    logic [WIDTH:0] sra_w;

    assign sll_w = {1'b0, data_i} << amt_i;
    assign srl_w = {data_i, 1'b0} >> amt_i;
    assign sra_w = $signed({data_i, 1'b0}) >>> amt_i;

    // Select the shifted word and shifted-out bit for the requested mode.
    always_comb begin
        data_o    = data_i;
        out_bit_o = 1'b0;
        case (mode_i)
            OP_SLL: begin
                data_o    = sll_w[WIDTH-1:0];
                out_bit_o = sll_w[WIDTH];
            end
            OP_SRL: begin
                data_o    = srl_w[WIDTH:1];
                out_bit_o = srl_w[0];
            end
            OP_SRA: begin
                data_o    = sra_w[WIDTH:1];
                out_bit_o = sra_w[0];
            end
            default: begin
                data_o    = data_i;
                out_bit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, multi-cycle shifts of
// up to STEP bits per cycle, valid/ready handshake on both sides.
module alu_seq
    import alu_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       os,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] sr2,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             zeroflag,
    output logic             negflag,
    output logic             carryflag,
    output logic             ovflag,
    output logic             busy
);

    localparam int             AW     = $clog2(STEP + 1);
    localparam int             SHW1   = SHW + 1;
    localparam int             MSB    = WIDTH - 1;
    localparam logic [SHW:0]   STEP_W = SHW1'(STEP);
    localparam logic [AW-1:0]  STEP_A = AW'(STEP);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [AW-1:0]    step_amt;
    logic [SHW-1:0]   rem_next;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;
    logic             load;
    logic [WIDTH-1:0] done_res;
    logic             done_c;
    logic             done_v;

    assign add_ext = {1'b0, sr1} + {1'b0, sr2};
    assign sub_ext = {1'b0, sr1} - {1'b0, sr2};

    // Per-cycle shift amount is min(STEP, remaining).
    always_comb begin
        step_amt = STEP_A;
        if ({1'b0, rem_q} < STEP_W) begin
            step_amt = AW'(rem_q);
        end
        rem_next = rem_q - SHW'(step_amt);
    end

    alu_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i    (sh_q),
        .amt_i     (step_amt),
        .mode_i    (op_q),
        .data_o    (step_data),
        .out_bit_o (step_bit)
    );

    // Next-state and datapath: every path into DONE goes through 'load',
    // which registers the result and derives zero/neg from it.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sh_d     = sh_q;
        rem_d    = rem_q;
        rd_d     = rd_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        load     = 1'b0;
        done_res = '0;
        done_c   = 1'b0;
        done_v   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = op_e'(os);
                    case (op_e'(os))
                        OP_ADD: begin
                            load     = 1'b1;
                            done_res = add_ext[WIDTH-1:0];
                            done_c   = add_ext[WIDTH];
                            done_v   = (sr1[MSB] == sr2[MSB]) && (add_ext[MSB] != sr1[MSB]);
                        end
                        OP_SUB: begin
                            load     = 1'b1;
                            done_res = sub_ext[WIDTH-1:0];
                            done_c   = sub_ext[WIDTH];
                            done_v   = (sr1[MSB] != sr2[MSB]) && (sub_ext[MSB] != sr1[MSB]);
                        end
                        OP_AND: begin
                            load     = 1'b1;
                            done_res = sr1 & sr2;
                        end
                        OP_OR: begin
                            load     = 1'b1;
                            done_res = sr1 | sr2;
                        end
                        OP_XOR: begin
                            load     = 1'b1;
                            done_res = sr1 ^ sr2;
                        end
                        default: begin
                            if (shift == '0) begin
                                load     = 1'b1;
                                done_res = sr1;
                            end else begin
                                sh_d    = sr1;
                                rem_d   = shift;
                                state_d = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                sh_d  = step_data;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    load     = 1'b1;
                    done_res = step_data;
                    done_c   = step_bit;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d = ST_DONE;
            rd_d    = done_res;
            z_d     = (done_res == '0);
            n_d     = done_res[MSB];
            c_d     = done_c;
            v_d     = done_v;
        end
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            sh_q    <= '0;
            rem_q   <= '0;
            rd_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            rd_q    <= rd_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign rd        = rd_q;
    assign zeroflag  = z_q;
    assign negflag   = n_q;
    assign carryflag = c_q;
    assign ovflag    = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: instance 0 uses STEP=1, instance 1 uses STEP=4.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] rd;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic [7:0]  lat;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [2:0]  os        [2];
    logic [31:0] sr1       [2];
    logic [31:0] sr2       [2];
    logic [4:0]  shift     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] rd        [2];
    logic        zf        [2];
    logic        nf        [2];
    logic        cf        [2];
    logic        vf        [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .os(os[0]), .sr1(sr1[0]), .sr2(sr2[0]), .shift(shift[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .rd(rd[0]),
        .zeroflag(zf[0]), .negflag(nf[0]), .carryflag(cf[0]), .ovflag(vf[0]), .busy(busy[0])
    );

    alu_seq #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .os(os[1]), .sr1(sr1[1]), .sr2(sr2[1]), .shift(shift[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .rd(rd[1]),
        .zeroflag(zf[1]), .negflag(nf[1]), .carryflag(cf[1]), .ovflag(vf[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the opcode definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int sh, input int step);
        exp_t        e;
        logic [63:0] w;
        longint      sa, sb, s;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e     = '0;
        e.lat = 8'd1;
        case (op)
            3'd0: begin
                w    = 64'(a) + 64'(b);
                e.rd = w[31:0];
                e.c  = w[32];
                s    = sa + sb;
                e.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                e.rd = a - b;
                e.c  = (a < b);
                s    = sa - sb;
                e.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: e.rd = a & b;
            3'd3: e.rd = a | b;
            3'd4: e.rd = a ^ b;
            3'd5: begin
                w    = 64'(a) << sh;
                e.rd = w[31:0];
                e.c  = (sh == 0) ? 1'b0 : w[32];
            end
            3'd6: begin
                e.rd = a >> sh;
                e.c  = (sh == 0) ? 1'b0 : a[sh-1];
            end
            default: begin
                e.rd = $signed(a) >>> sh;
                e.c  = (sh == 0) ? 1'b0 : a[sh-1];
            end
        endcase
        if (op >= 3'd5 && sh != 0) e.lat = 8'((sh + step - 1) / step + 1);
        e.z = (e.rd == 32'd0);
        e.n = e.rd[31];
        return e;
    endfunction

    // Scoreboard state for the per-cycle compare process.
    logic pend [2];
    logic seen [2];
    int   age  [2];
    exp_t ex   [2];
    logic was_p;

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                pend[k] = 1'b0;
                seen[k] = 1'b0;
                chk($sformatf("rst_valid%0d", k), out_valid[k], 1'b0);
                chk($sformatf("rst_rd%0d", k), rd[k], 32'd0);
                chk($sformatf("rst_flags%0d", k), {zf[k], nf[k], cf[k], vf[k]}, 4'b0000);
                chk($sformatf("rst_busy%0d", k), busy[k], 1'b0);
                chk($sformatf("rst_in_ready%0d", k), in_ready[k], 1'b1);
            end else begin
                was_p = pend[k];
                chk($sformatf("in_ready%0d", k), in_ready[k], !was_p);
                chk($sformatf("busy%0d", k), busy[k], was_p);
                if (was_p) begin
                    age[k]++;
                    chk($sformatf("out_valid%0d", k), out_valid[k], age[k] >= int'(ex[k].lat));
                    if (out_valid[k]) begin
                        chk($sformatf("rd%0d", k), rd[k], ex[k].rd);
                        chk($sformatf("flags%0d", k), {zf[k], nf[k], cf[k], vf[k]},
                            {ex[k].z, ex[k].n, ex[k].c, ex[k].v});
                        if (out_ready[k]) begin
                            pend[k] = 1'b0;
                            seen[k] = 1'b1;
                        end
                    end
                end else begin
                    chk($sformatf("idle_valid%0d", k), out_valid[k], 1'b0);
                    if (!seen[k]) begin
                        chk($sformatf("pre_rd%0d", k), rd[k], 32'd0);
                        chk($sformatf("pre_flags%0d", k), {zf[k], nf[k], cf[k], vf[k]}, 4'b0000);
                    end
                    if (in_valid[k]) begin
                        ex[k]   = model(os[k], sr1[k], sr2[k], int'(shift[k]), (k == 0) ? 1 : 4);
                        pend[k] = 1'b1;
                        age[k]  = 0;
                    end
                end
            end
        end
    end

    // Issue one op, feed junk while busy, hold off out_ready, then retire it.
    task automatic run_op(input int k, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int hold,
                          input logic [31:0] exp_rd, input logic [3:0] exp_fl, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        in_valid[k]  = 1'b1;
        os[k]        = op;
        sr1[k]       = a;
        sr2[k]       = b;
        shift[k]     = sh;
        out_ready[k] = 1'b0;
        @(posedge clk); #1;
        os[k]    = ~op;
        sr1[k]   = ~a;
        sr2[k]   = ~b;
        shift[k] = ~sh;
        lat = 1;
        while (!out_valid[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid[k] = 1'b0;
        chk($sformatf("lat%0d_op%0d", k, op), lat, exp_lat);
        chk($sformatf("lit_rd%0d_op%0d", k, op), rd[k], exp_rd);
        chk($sformatf("lit_flags%0d_op%0d", k, op), {zf[k], nf[k], cf[k], vf[k]}, exp_fl);
        repeat (hold) begin
            @(posedge clk); #1;
            chk($sformatf("bp_in_ready%0d", k), in_ready[k], 1'b0);
            chk($sformatf("bp_rd%0d", k), rd[k], exp_rd);
            chk($sformatf("bp_valid%0d", k), out_valid[k], 1'b1);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk($sformatf("ret_in_ready%0d", k), in_ready[k], 1'b1);
        chk($sformatf("ret_valid%0d", k), out_valid[k], 1'b0);
    endtask

    initial begin
        exp_t m;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; os[k] = 3'd0; sr1[k] = '0; sr2[k] = '0;
            shift[k] = '0; out_ready[k] = 1'b0;
            pend[k] = 1'b0; seen[k] = 1'b0; age[k] = 0; ex[k] = '0;
        end
        reset_n = 1'b0;

        // Hand-computed pins on the model itself.
        m = model(3'd0, 32'h9, 32'h1, 0, 1);
        chk("model_add", {m.rd, m.lat}, {32'hA, 8'd1});
        m = model(3'd5, 32'h9, 32'h0, 2, 1);
        chk("model_sll", {m.rd, m.lat}, {32'h24, 8'd3});
        m = model(3'd7, 32'h8000_0000, 32'h0, 31, 4);
        chk("model_sra", {m.rd, m.lat}, {32'hFFFF_FFFF, 8'd9});

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // {zero, neg, carry, ovf}
        run_op(0, 3'd0, 32'h9,         32'h1,         5'd0,  0, 32'hA,         4'b0000, 1);
        run_op(0, 3'd1, 32'h1,         32'h1,         5'd0,  0, 32'h0,         4'b1000, 1);
        run_op(0, 3'd0, 32'h7FFF_FFFF, 32'h1,         5'd0,  0, 32'h8000_0000, 4'b0101, 1);
        run_op(0, 3'd1, 32'h0,         32'h1,         5'd0,  0, 32'hFFFF_FFFF, 4'b0110, 1);
        run_op(0, 3'd0, 32'hFFFF_FFFF, 32'h1,         5'd0,  0, 32'h0,         4'b1010, 1);
        run_op(0, 3'd1, 32'h8000_0000, 32'h1,         5'd0,  0, 32'h7FFF_FFFF, 4'b0001, 1);
        run_op(0, 3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  0, 32'h00F0_1234, 4'b0000, 1);
        run_op(0, 3'd3, 32'h8000_0000, 32'h1,         5'd0,  0, 32'h8000_0001, 4'b0100, 1);
        run_op(0, 3'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd0,  0, 32'h0,         4'b1000, 1);
        run_op(0, 3'd5, 32'h9,         32'h0,         5'd2,  5, 32'h24,        4'b0000, 3);
        run_op(0, 3'd5, 32'hC000_0001, 32'h0,         5'd1,  0, 32'h8000_0002, 4'b0110, 2);
        run_op(0, 3'd6, 32'h8000_0003, 32'h0,         5'd1,  0, 32'h4000_0001, 4'b0010, 2);
        run_op(0, 3'd7, 32'h8000_0000, 32'h0,         5'd4,  0, 32'hF800_0000, 4'b0100, 5);
        run_op(0, 3'd6, 32'h1234,      32'h0,         5'd0,  0, 32'h1234,      4'b0000, 1);
        run_op(0, 3'd5, 32'h1,         32'h0,         5'd31, 0, 32'h8000_0000, 4'b0100, 32);
        run_op(1, 3'd7, 32'h8000_0000, 32'h0,         5'd31, 2, 32'hFFFF_FFFF, 4'b0100, 9);
        run_op(1, 3'd6, 32'hFFFF_FFFF, 32'h0,         5'd5,  0, 32'h07FF_FFFF, 4'b0010, 3);
        run_op(1, 3'd5, 32'h1,         32'h0,         5'd4,  0, 32'h10,        4'b0000, 2);

        // Abort a shift with an asynchronous reset pulse.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; os[0] = 3'd5; sr1[0] = 32'h1; shift[0] = 5'd20;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_valid", out_valid[0], 1'b0);
        chk("async_rd", rd[0], 32'd0);
        chk("async_busy", busy[0], 1'b0);
        chk("async_in_ready", in_ready[0], 1'b1);
        @(posedge clk); #1 reset_n = 1'b1;
        run_op(0, 3'd0, 32'h9, 32'h1, 5'd0, 0, 32'hA, 4'b0000, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
